// File: rtl/reg_file_scoreboard.sv
// 32x32 MIPS general-purpose register file with a write-back scoreboard.
// Tracks destinations of issued-but-not-yet-written-back instructions and
// flags read-after-write and write-after-write hazards to decode. A
// write-back arriving in the same cycle is forwarded to the read ports and
// resolves any hazard it covers.
module reg_file_scoreboard #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        Read_Register1,
    input  logic [4:0]        Read_Register2,
    output logic [DATA_W-1:0] Read_Data1,
    output logic [DATA_W-1:0] Read_Data2,
    output logic              Read_Busy1,
    output logic              Read_Busy2,
    input  logic              Issue_Valid,
    input  logic [4:0]        Issue_Register,
    output logic              Stall,
    input  logic              RegWrite,
    input  logic [4:0]        Write_Register,
    input  logic [DATA_W-1:0] Write_Data,
    output logic [5:0]        Busy_Count
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;
    logic [5:0]        busy_count_q;
    logic [5:0]        busy_count_d;

    logic wb_hit1, wb_hit2, wb_hit_dest;
    logic dest_busy;
    logic issue_accept;
    logic wb_en;

    // A write-back to r0 is architecturally a no-op.
    assign wb_en = RegWrite && (Write_Register != 5'd0);

    // Same-cycle write-back matches against each looked-up register.
    assign wb_hit1     = RegWrite && (Write_Register == Read_Register1);
    assign wb_hit2     = RegWrite && (Write_Register == Read_Register2);
    assign wb_hit_dest = RegWrite && (Write_Register == Issue_Register);

    // Read ports: r0 is hard-wired to zero, otherwise forward write-back data.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        Read_Data1 = '0;
        Read_Data2 = '0;
        if (Read_Register1 != 5'd0) begin
            Read_Data1 = wb_hit1 ? Write_Data : regs_q[Read_Register1];
        end
        if (Read_Register2 != 5'd0) begin
            Read_Data2 = wb_hit2 ? Write_Data : regs_q[Read_Register2];
        end
    end

    // busy_q[0] is never set, so r0 can never report a hazard.
    assign Read_Busy1   = busy_q[Read_Register1] && !wb_hit1;
    assign Read_Busy2   = busy_q[Read_Register2] && !wb_hit2;
    assign dest_busy    = busy_q[Issue_Register] && !wb_hit_dest;
    assign Stall        = Issue_Valid && (Read_Busy1 || Read_Busy2 || dest_busy);
    assign issue_accept = Issue_Valid && !Stall;

    // Next busy vector: write-back clears first, an accepted issue then sets,
    // so an issue and write-back to the same register leave it busy.
    always_comb begin
        busy_d = busy_q;
        if (wb_en) begin
            busy_d[Write_Register] = 1'b0;
        end
        if (issue_accept && (Issue_Register != 5'd0)) begin
            busy_d[Issue_Register] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Population count of the next busy vector, registered as Busy_Count.
    always_comb begin
        busy_count_d = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_count_d = busy_count_d + 6'(busy_d[i]);
        end
    end

    // Scoreboard state and busy count; reset discards any same-cycle issue or write-back.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only, so every reader sees pre-edge values.
        if (rst) begin
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    // Register array write port; the whole array clears on reset.
    always_ff @(posedge clk) begin
        // NOTE: the array is reset because every register must read zero after reset; this keeps it in flops rather than RAM.
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en) begin
            regs_q[Write_Register] <= Write_Data;
        end
    end

    assign Busy_Count = busy_count_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Self-checking bench for reg_file_scoreboard: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against an
// array-based architectural model of registers and pending writes.
module tb_reg_file_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  Read_Register1, Read_Register2;
    logic [31:0] Read_Data1, Read_Data2;
    logic        Read_Busy1, Read_Busy2;
    logic        Issue_Valid;
    logic [4:0]  Issue_Register;
    logic        Stall;
    logic        RegWrite;
    logic [4:0]  Write_Register;
    logic [31:0] Write_Data;
    logic [5:0]  Busy_Count;

    int total = 0;
    int bad   = 0;

    // Architectural model: register contents and set of pending destinations.
    logic [31:0] mreg [32];
    bit          mbusy [32];
    bit          model_valid = 1'b0;

    reg_file_scoreboard #(.DATA_W(32), .NREG(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .Read_Register1 (Read_Register1),
        .Read_Register2 (Read_Register2),
        .Read_Data1     (Read_Data1),
        .Read_Data2     (Read_Data2),
        .Read_Busy1     (Read_Busy1),
        .Read_Busy2     (Read_Busy2),
        .Issue_Valid    (Issue_Valid),
        .Issue_Register (Issue_Register),
        .Stall          (Stall),
        .RegWrite       (RegWrite),
        .Write_Register (Write_Register),
        .Write_Data     (Write_Data),
        .Busy_Count     (Busy_Count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- model queries (architectural rules) ----
    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (RegWrite && Write_Register == a) return Write_Data;
        return mreg[a];
    endfunction

    function automatic bit m_pending(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        return mbusy[a] && !(RegWrite && Write_Register == a);
    endfunction

    function automatic bit m_stall();
        return Issue_Valid && (m_pending(Read_Register1) || m_pending(Read_Register2)
                               || m_pending(Issue_Register));
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(mbusy[i]);
        return n;
    endfunction

    // Model update at each rising edge using the inputs held across it.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mreg[i]  = 32'd0;
                mbusy[i] = 1'b0;
            end
            model_valid = 1'b1;
        end else begin
            bit acc;
            acc = Issue_Valid && !m_stall();
            if (RegWrite && Write_Register != 5'd0) begin
                mreg[Write_Register]  = Write_Data;
                mbusy[Write_Register] = 1'b0;
            end
            if (acc && Issue_Register != 5'd0) mbusy[Issue_Register] = 1'b1;
        end
    end

    // Compare process: every falling edge once the model is defined.
    always @(negedge clk) begin
        if (model_valid) begin
            check("rd1",   Read_Data1, m_read(Read_Register1));
            check("rd2",   Read_Data2, m_read(Read_Register2));
            check("busy1", 32'(Read_Busy1), 32'(m_pending(Read_Register1)));
            check("busy2", 32'(Read_Busy2), 32'(m_pending(Read_Register2)));
            check("stall", 32'(Stall), 32'(m_stall()));
            check("count", 32'(Busy_Count), 32'(m_count()));
        end
    end

    // Apply one cycle of inputs just after a rising edge.
    task automatic drive(input logic r, input logic [4:0] r1, input logic [4:0] r2,
                         input logic iv, input logic [4:0] ir,
                         input logic rw, input logic [4:0] wr, input logic [31:0] wd);
        @(posedge clk);
        #1;
        rst = r; Read_Register1 = r1; Read_Register2 = r2;
        Issue_Valid = iv; Issue_Register = ir;
        RegWrite = rw; Write_Register = wr; Write_Data = wd;
        #1;
    endtask

    initial begin
        rst = 1'b1; Read_Register1 = '0; Read_Register2 = '0;
        Issue_Valid = 1'b0; Issue_Register = '0;
        RegWrite = 1'b0; Write_Register = '0; Write_Data = '0;

        // Reset then read r5/r31.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 5, 31, 0, 0, 0, 0, 0);
        check("rst_rd1", Read_Data1, 32'd0);
        check("rst_rd2", Read_Data2, 32'd0);
        check("rst_busy1", 32'(Read_Busy1), 32'd0);
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_count", 32'(Busy_Count), 32'd0);

        // Write with same-cycle bypass, then plain read.
        drive(0, 8, 0, 0, 0, 1, 8, 32'hDEADBEEF);
        check("bypass_rd1", Read_Data1, 32'hDEADBEEF);
        drive(0, 8, 0, 0, 0, 0, 0, 0);
        check("stored_rd1", Read_Data1, 32'hDEADBEEF);

        // r0 protection: write and issue to r0.
        drive(0, 0, 0, 1, 0, 1, 0, 32'h12345678);
        check("r0_bypass", Read_Data1, 32'd0);
        check("r0_stall", 32'(Stall), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("r0_rd", Read_Data1, 32'd0);
        check("r0_busy", 32'(Read_Busy1), 32'd0);
        check("r0_count", 32'(Busy_Count), 32'd0);

        // RAW: issue r3, then read r3 stalls until its write-back arrives.
        drive(0, 0, 0, 1, 3, 0, 0, 0);
        check("raw_issue_ok", 32'(Stall), 32'd0);
        drive(0, 3, 0, 1, 0, 0, 0, 0);
        check("raw_count", 32'(Busy_Count), 32'd1);
        check("raw_stall", 32'(Stall), 32'd1);
        check("raw_busy1", 32'(Read_Busy1), 32'd1);
        drive(0, 3, 0, 1, 0, 1, 3, 32'h55);
        check("raw_res_stall", 32'(Stall), 32'd0);
        check("raw_res_rd1", Read_Data1, 32'h55);
        drive(0, 3, 0, 0, 0, 0, 0, 0);
        check("raw_clear_count", 32'(Busy_Count), 32'd0);

        // WAW and simultaneous issue + write-back to the same register.
        drive(0, 0, 0, 1, 4, 0, 0, 0);
        drive(0, 0, 0, 1, 4, 0, 0, 0);
        check("waw_count", 32'(Busy_Count), 32'd1);
        check("waw_stall", 32'(Stall), 32'd1);
        drive(0, 4, 0, 1, 4, 1, 4, 32'hAA);
        check("sim_stall", 32'(Stall), 32'd0);
        check("sim_bypass", Read_Data1, 32'hAA);
        drive(0, 4, 0, 0, 0, 0, 0, 0);
        check("sim_count", 32'(Busy_Count), 32'd1);
        check("sim_busy", 32'(Read_Busy1), 32'd1);
        check("sim_rd", Read_Data1, 32'hAA);

        // Reset mid-operation with a concurrent write-back to r7.
        drive(0, 0, 0, 1, 2, 1, 2, 32'h99);
        drive(0, 0, 0, 1, 7, 0, 0, 0);
        drive(0, 2, 7, 0, 0, 0, 0, 0);
        check("pre_rst_rd1", Read_Data1, 32'h99);
        check("pre_rst_busy2", 32'(Read_Busy2), 32'd1);
        check("pre_rst_count", 32'(Busy_Count), 32'd3);
        drive(1, 2, 7, 0, 0, 1, 7, 32'h77);
        drive(0, 2, 7, 0, 0, 0, 0, 0);
        check("mid_rst_rd1", Read_Data1, 32'd0);
        check("mid_rst_rd2", Read_Data2, 32'd0);
        check("mid_rst_busy1", 32'(Read_Busy1), 32'd0);
        check("mid_rst_busy2", 32'(Read_Busy2), 32'd0);
        check("mid_rst_count", 32'(Busy_Count), 32'd0);

        // Randomized traffic on a narrow register window to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] hi;
            hi = (n < 1500) ? 5'd7 : 5'd31;
            drive(($urandom_range(0, 127) == 0),
                  5'($urandom_range(0, int'(hi))), 5'($urandom_range(0, int'(hi))),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, int'(hi))),
                  ($urandom_range(0, 2) != 0), 5'($urandom_range(0, int'(hi))),
                  $urandom());
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #6;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
32x32 MIPS general-purpose register file with a write-back scoreboard. It is the consumer of the write-back path: it takes the selected destination register (Write_Register) and the selected write-back data (Write_Data). It tracks destinations of issued-but-not-written-back instructions and flags read-after-write hazards to the decode stage. Same-cycle write-back is forwarded to the read ports.

Parameters:
DATA_W, 32, register width
NREG, 32, number of registers (address width fixed at 5)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
Read_Register1  input  5  read port 1 address
Read_Register2  input  5  read port 2 address
Read_Data1  output  32  read port 1 data
Read_Data2  output  32  read port 2 data
Read_Busy1  output  1  port 1 register has pending write not resolved this cycle
Read_Busy2  output  1  port 2 register has pending write not resolved this cycle
Issue_Valid  input  1  decode requests issue of an instruction writing Issue_Register
Issue_Register  input  5  destination of issuing instruction
Stall  output  1  issue refused this cycle
RegWrite  input  1  write-back enable
Write_Register  input  5  write-back destination
Write_Data  input  32  write-back data
Busy_Count  output  6  registered count of busy registers (0..31)

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high. On a rst edge, all 32 registers clear to 0, the busy vector clears to 0, and Busy_Count clears to 0.
- Reset priority: rst has priority over a simultaneous write-back or issue, and both are discarded.
- Read_Data1/2, Read_Busy1/2 and Stall are combinational from current state and inputs.
- After the first rst edge with no writes, Read_Data reads 0 and Read_Busy and Stall read 0.
- r0: always reads 0 and is never busy. A write-back to r0 is ignored. An issue to r0 is accepted without setting any busy bit.
- Write: on posedge, if RegWrite and Write_Register!=0, then reg[Write_Register] <= Write_Data and busy[Write_Register] <= 0, unless the same register is set by an accepted issue in the same cycle.
- Write-back to a non-busy register: data is written, and the busy bit stays 0.
- Bypass: if RegWrite and Write_Register==Read_RegisterN and the address is nonzero, Read_DataN = Write_Data in the same cycle. Otherwise Read_DataN = reg[Read_RegisterN].
- ReadBusy (per port N): Read_BusyN = busy[Read_RegisterN] AND NOT (RegWrite AND Write_Register==Read_RegisterN). A write-back in the same cycle resolves the hazard.
- DestBusy: DestBusy = busy[Issue_Register] AND NOT (RegWrite AND Write_Register==Issue_Register).
- Stall = Issue_Valid AND (Read_Busy1 OR Read_Busy2 OR DestBusy). This refuses WAW as well as RAW hazards.
- Accepted issue = Issue_Valid AND NOT Stall. On posedge, an accepted issue sets busy[Issue_Register] <= 1 if Issue_Register!=0.
- Simultaneous events:
  - Write-back clear and issue set to the same register in one cycle: the set wins, so the register ends busy and holds the new data.
  - Write-back and issue to different registers: both apply independently.
- Refused issue: no state change from the issue side. Decode holds Issue_Valid and the operands. Write-back continues.
- Busy_Count: registered popcount of the next-state busy vector, valid the cycle after each edge.
- No latency beyond one edge for any state update. No internal FSM beyond the busy vector. Throughput is one issue and one write-back per cycle.

Test Plan:
- Reset then read: assert rst 1 cycle, read r5/r31 -> Read_Data1/2=0, Read_Busy=0, Stall=0, Busy_Count=0.
- Write and bypass: RegWrite=1, Write_Register=8, Write_Data=0xDEADBEEF, Read_Register1=8 in the same cycle -> Read_Data1=0xDEADBEEF combinationally. Next cycle, with RegWrite=0 -> still 0xDEADBEEF.
- r0 protection: write 0x12345678 to r0, issue to r0 -> Read_Data of r0=0, no busy bit, Busy_Count=0.
- RAW stall:
  - Issue r3 (accepted), next cycle -> Busy_Count=1.
  - Issue with Read_Register1=3 -> Stall=1, Read_Busy1=1.
  - Write-back r3 data 0x55 in the same cycle -> Stall=0, Read_Data1=0x55.
- WAW and simultaneous: with r4 busy, issue r4 alone -> Stall=1. Issue r4 with write-back r4 (0xAA) in the same cycle -> accepted, r4 ends busy with reg=0xAA, Busy_Count=1.
- Reset mid-operation: r2 and r7 busy and r2=0x99, assert rst together with RegWrite to r7 -> all registers 0, busy cleared, Busy_Count=0, no write to r7.
